// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a zero-wait combinational memory and
// queues {PC, word} pairs for decode. Optional PC bound check enabled by FETCH_BOUND_CHECK_EN.
module instruction_fetch_unit #(
   parameter int                PCSize               = 32,
   parameter int                InstructionSize      = 32,
   parameter int                AmountOfInstructions = 128,
   parameter int                BufferDepth          = 4,
   parameter logic [PCSize-1:0] ResetVector          = '0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic [PCSize-1:0]                    PC,
   input  logic [InstructionSize-1:0]           Instruction,
   input  logic                                 Redirect,
   input  logic [PCSize-1:0]                    RedirectTarget,
   output logic [InstructionSize-1:0]           InstrOut,
   output logic [PCSize-1:0]                    InstrPC,
   output logic                                 InstrValid,
   input  logic                                 InstrReady,
   output logic [$clog2(BufferDepth):0]         BufferCount,
   output logic                                 FetchFault
);
   localparam int               PtrW     = $clog2(BufferDepth);
   localparam int               CntW     = PtrW + 1;
   localparam logic [CntW-1:0]  DepthCnt = CntW'(BufferDepth);
   localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
   localparam logic [PCSize-1:0] PcStep  = PCSize'(4);

   logic [PCSize-1:0]          pc_q, pc_d;
   logic [PtrW-1:0]            head_q, head_d;
   logic [PtrW-1:0]            tail_q, tail_d;
   logic [CntW-1:0]            count_q, count_d;
   logic                       fault_q, fault_d;
   logic [InstructionSize-1:0] out_instr_q, out_instr_d;
   logic [PCSize-1:0]          out_pc_q, out_pc_d;

   logic [InstructionSize-1:0] buf_instr_q [BufferDepth];
   logic [PCSize-1:0]          buf_pc_q    [BufferDepth];

   logic valid;
   logic pop;
   logic push_req;
   logic push;
   logic out_of_bounds;

   assign valid    = (count_q != '0);
   assign pop      = valid & InstrReady & ~Redirect;
   assign push_req = ~Redirect & ((count_q < DepthCnt) | pop) & ~fault_q;

`ifdef FETCH_BOUND_CHECK_EN
   localparam logic [PCSize:0] PcLimit = (PCSize+1)'(AmountOfInstructions * 4);
   assign out_of_bounds = ({1'b0, pc_q} >= PcLimit);
`else
   logic unused_bound;
   assign unused_bound  = (AmountOfInstructions > 0);
   assign out_of_bounds = 1'b0;
`endif

   assign push = push_req & ~out_of_bounds;

   always_comb begin
      pc_d        = pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      fault_d     = fault_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (Redirect) begin
         pc_d    = {RedirectTarget[PCSize-1:2], 2'b00};
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         fault_d = 1'b0;
      end else begin
         if (push_req & out_of_bounds) begin
            fault_d = 1'b1;
         end
         if (pop) begin
            head_d = head_q + PtrOne;
         end
         if (push) begin
            tail_d = tail_q + PtrOne;
            pc_d   = pc_q + PcStep;
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
         // New head is the slot being written this edge only when the buffer drains to it.
         if (count_d != '0) begin
            if (push && (head_d == tail_q)) begin
               out_instr_d = Instruction;
               out_pc_d    = pc_q;
            end else begin
               out_instr_d = buf_instr_q[head_d];
               out_pc_d    = buf_pc_q[head_d];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= ResetVector;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         fault_q     <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         fault_q     <= fault_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[tail_q] <= Instruction;
         buf_pc_q[tail_q]    <= pc_q;
      end
   end

   assign PC          = pc_q;
   assign InstrOut    = out_instr_q;
   assign InstrPC     = out_pc_q;
   assign InstrValid  = valid;
   assign BufferCount = count_q;
   assign FetchFault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed steps plus random traffic checked against
// a queue-based reference model of the fetch buffer.
module tb_instruction_fetch_unit;
   localparam int Depth  = 4;
   localparam int Amount = 8;
`ifdef FETCH_BOUND_CHECK_EN
   localparam bit BoundEn = 1'b1;
`else
   localparam bit BoundEn = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   logic        clk;
   logic        rst;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic [2:0]  BufferCount;
   logic        FetchFault;
   logic [31:0] salt;

   int vectors;
   int miscompares;

   // reference model state
   entry_t      m_q[$];
   logic [31:0] m_pc;
   bit          m_fault;
   logic [31:0] m_out_pc;
   logic [31:0] m_out_ins;

   instruction_fetch_unit #(
      .PCSize(32), .InstructionSize(32), .AmountOfInstructions(Amount),
      .BufferDepth(Depth), .ResetVector(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
      .Redirect(Redirect), .RedirectTarget(RedirectTarget),
      .InstrOut(InstrOut), .InstrPC(InstrPC), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .BufferCount(BufferCount), .FetchFault(FetchFault)
   );

   // combinational instruction memory
   assign Instruction = (PC >> 2) ^ salt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) ^ salt;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_fault   = 1'b0;
      m_out_pc  = 32'h0;
      m_out_ins = 32'h0;
   endtask

   task automatic model_step(input bit redir, input logic [31:0] tgt, input bit ready);
      bit pop;
      bit room;
      if (redir) begin
         m_q.delete();
         m_pc    = {tgt[31:2], 2'b00};
         m_fault = 1'b0;
      end else begin
         pop  = (m_q.size() > 0) && ready;
         room = (m_q.size() < Depth) || pop;
         if (pop) void'(m_q.pop_front());
         if (room && !m_fault) begin
            if (BoundEn && (m_pc >= Amount * 4)) begin
               m_fault = 1'b1;
            end else begin
               m_q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
         if (m_q.size() > 0) begin
            m_out_pc  = m_q[0].pc;
            m_out_ins = m_q[0].ins;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    PC, m_pc);
      check({tag, ".valid"}, InstrValid, (m_q.size() > 0));
      check({tag, ".count"}, BufferCount, m_q.size());
      check({tag, ".fault"}, FetchFault, m_fault);
      check({tag, ".ipc"},   InstrPC, m_out_pc);
      check({tag, ".iout"},  InstrOut, m_out_ins);
   endtask

   task automatic cycle(input bit redir, input logic [31:0] tgt, input bit ready, input string tag);
      Redirect       = redir;
      RedirectTarget = tgt;
      InstrReady     = ready;
      model_step(redir, tgt, ready);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] tgt;
      vectors     = 0;
      miscompares = 0;
      salt        = 32'h0;
      rst         = 1'b1;
      Redirect    = 1'b0;
      RedirectTarget = 32'h0;
      InstrReady  = 1'b0;
      model_reset();

      #12;
      check_all("reset");
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 32'h0, 1'b1, "stream");
         check("stream.seq_pc", InstrPC, i * 4);
         check("stream.seq_ins", InstrOut, i);
      end

      do_reset("rst2");
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, "stall");
      check("stall.count", BufferCount, 4);
      check("stall.pc", PC, 32'd16);
      cycle(1'b0, 32'h0, 1'b1, "pushpop");
      check("pushpop.count", BufferCount, 4);
      check("pushpop.pc", PC, 32'd20);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, "drain");

      cycle(1'b1, 32'h0, 1'b0, "redir0");
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, "fill3");
      check("fill3.count", BufferCount, 3);
      cycle(1'b1, 32'h47, 1'b1, "redir47");
      check("redir47.valid", InstrValid, 0);
      check("redir47.pc", PC, 32'h44);
      cycle(1'b0, 32'h0, 1'b1, "after47");
      check("after47.ipc", InstrPC, 32'h44);

      cycle(1'b1, 32'h100, 1'b1, "redir_hold");
      cycle(1'b1, 32'h203, 1'b1, "redir_hold");
      cycle(1'b1, 32'h30, 1'b0, "redir_hold");
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, "fillfull");
      do_reset("async_rst");
      check("async_rst.pc", PC, 0);

      cycle(1'b1, 32'hFFFFFFF5, 1'b0, "wrap_redir");
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, "wrap");

`ifdef FETCH_BOUND_CHECK_EN
      do_reset("bound_rst");
      for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1, "bound");
      check("bound.last_ipc", InstrPC, 32'h1C);
      check("bound.fault", FetchFault, 1);
      check("bound.pc", PC, 32'h20);
      cycle(1'b1, 32'h0, 1'b1, "bound_clear");
      check("bound_clear.fault", FetchFault, 0);
      cycle(1'b0, 32'h0, 1'b1, "bound_restart");
      check("bound_restart.ipc", InstrPC, 32'h0);
`endif

      salt = $urandom;
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 2))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFFFFE0 | ($urandom & 32'h1F);
            default: tgt = $urandom_range(0, 40);
         endcase
         cycle(($urandom_range(0, 15) == 0), tgt, ($urandom_range(0, 2) != 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter, drives PC to the combinational InstructionMemory and captures the returned Instruction.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports branch redirect with buffer flush.

Parameters:
- PCSize, 32, width of PC and redirect target.
- InstructionSize, 32, width of an instruction word.
- AmountOfInstructions, 128, number of words in instruction memory; used only by the optional bound check.
- BufferDepth, 4, FIFO entries (power of two, >=2).
- ResetVector, 0, PC value after reset (word aligned).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- PC  output  PCSize  fetch address to InstructionMemory
- Instruction  input  InstructionSize  word returned combinationally for PC
- Redirect  input  1  load new fetch address, flush buffer
- RedirectTarget  input  PCSize  new fetch address
- InstrOut  output  InstructionSize  head-of-buffer instruction
- InstrPC  output  PCSize  PC of InstrOut
- InstrValid  output  1  head entry valid
- InstrReady  input  1  decode accepts head entry
- BufferCount  output  $clog2(BufferDepth)+1  occupied entries
- FetchFault  output  1  bound-check fault (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, immediate):
  - PC=ResetVector; buffer empty, pointers 0.
  - InstrValid=0, BufferCount=0, FetchFault=0.
  - InstrOut and InstrPC = 0.
- Fetch: PC is a register. Instruction is sampled on the same edge at which PC advances (memory is combinational, zero wait).
- Pop = InstrValid & InstrReady.
- Push = !Redirect & (count<BufferDepth | Pop) & !FetchFault.
- On push: write {PC, Instruction} at tail; PC <= PC+4, modulo 2^PCSize (wraps 0xFFFFFFFC -> 0).
- Full and no pop: PC holds; no push.
- Full with pop in the same cycle: push and pop both occur; count is unchanged.
- Empty: InstrValid=0. InstrOut/InstrPC hold their last value and are don't-care.
- Latency: a word fetched at edge N is visible on InstrOut with InstrValid=1 after edge N. After reset release, the first valid word appears one cycle later.
- InstrOut/InstrPC are driven from the head entry and change only on pop, push-into-empty, or flush.
- Redirect (highest priority):
  - At the edge, flush the buffer (count=0, pointers reset).
  - PC <= {RedirectTarget[PCSize-1:2], 2'b00}.
  - No push and no pop counted that cycle, even if InstrReady=1.
  - InstrValid=0 for exactly the following cycle, then fetching resumes from the target.
  - Clears FetchFault.
- Redirect held for consecutive cycles: each cycle reloads PC and flushes; no push occurs.
- rst mid-operation overrides everything, including Redirect.
- Invariants:
  - InstrPC entries are strictly PC-ordered (+4) between redirects.
  - No entry is dropped or duplicated under any InstrReady pattern.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN
- Defined:
  - If PC >= AmountOfInstructions*4 at an edge where a push would occur, do not push.
  - Set FetchFault=1 (sticky) and freeze PC.
  - Buffered entries still drain normally.
  - Only Redirect or rst clears the fault.
- Undefined: no check; FetchFault is tied to 0; PC runs through the full 2^PCSize space with wrap.

Test Plan:
- Reset release, InstrReady=1 constant, memory word=addr>>2 -> InstrPC sequence 0,4,8,12,16 on consecutive cycles; InstrOut 0,1,2,3,4; InstrValid=1 from cycle 1.
- InstrReady=0 for 10 cycles, BufferDepth=4 -> BufferCount saturates at 4, PC holds at 16. InstrReady=1 then yields PCs 0,4,8,12,16 with no gaps or duplicates.
- Buffer full, InstrReady=1 for one cycle -> simultaneous push/pop; BufferCount stays 4; PC advances 16->20.
- Redirect=1, RedirectTarget=0x47 while 3 entries buffered -> next cycle InstrValid=0, BufferCount=0, PC=0x44. Following cycle InstrPC=0x44.
- Assert rst asynchronously between edges with buffer full -> outputs reset immediately: PC=0, InstrValid=0, BufferCount=0.
- With FETCH_BOUND_CHECK_EN, AmountOfInstructions=8, InstrReady=1 -> last InstrPC=0x1C, FetchFault=1 and PC frozen at 0x20. Redirect to 0 clears the fault; fetch restarts at 0.
